// File: rtl/wisc_mem_pkg.sv
// Shared types and default geometry for the data-memory arbiter.
package wisc_mem_pkg;

    localparam int unsigned DMEM_ADDR_W  = 16;
    localparam int unsigned DMEM_DATA_W  = 16;
    localparam int unsigned DMEM_MEM_LAT = 4;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    typedef enum logic {
        OWN_PIPE,
        OWN_DMA
    } owner_t;

endpackage

// File: rtl/dmem_lat_ctr.sv
// Loadable down-counter with a zero flag; sets how long a memory access is held.
module dmem_lat_ctr #(
    parameter int unsigned WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - ONE;
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the pipeline MEM stage and a DMA/debug port,
// holding one latched request stable for MEM_LAT cycles.
module dmem_arbiter
    import wisc_mem_pkg::*;
#(
    parameter int unsigned ADDR_W     = DMEM_ADDR_W,
    parameter int unsigned DATA_W     = DMEM_DATA_W,
    parameter int unsigned MEM_LAT    = DMEM_MEM_LAT,
    parameter int unsigned STARVE_MAX = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_p_re,
    input  logic              i_p_we,
    input  logic [ADDR_W-1:0] i_p_addr,
    input  logic [DATA_W-1:0] i_p_wdata,
    output logic [DATA_W-1:0] o_p_rdata,
    output logic              o_p_stall,
    input  logic              i_d_req,
    input  logic              i_d_we,
    input  logic [ADDR_W-1:0] i_d_addr,
    input  logic [DATA_W-1:0] i_d_wdata,
    output logic              o_d_gnt,
    output logic              o_d_done,
    output logic [DATA_W-1:0] o_d_rdata,
    output logic [ADDR_W-1:0] o_m_addr,
    output logic [DATA_W-1:0] o_m_wdata,
    output logic              o_m_re,
    output logic              o_m_we,
    input  logic [DATA_W-1:0] i_m_rdata
);

    localparam int unsigned CTR_W = $clog2(MEM_LAT + 1);
    localparam int unsigned ST_W  = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

    localparam logic [CTR_W-1:0] LAT_LOAD = CTR_W'(MEM_LAT - 1);
    localparam logic [ST_W-1:0]  ST_SAT   = ST_W'(STARVE_MAX);
    localparam logic [ST_W-1:0]  ST_ONE   = ST_W'(1);

    state_t            r_state;
    state_t            w_state_d;
    owner_t            r_owner;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_we;
    logic [ST_W-1:0]   r_starve;
    logic [DATA_W-1:0] r_p_rdata;
    logic [DATA_W-1:0] r_d_rdata;

    logic w_p_req;
    logic w_starved;
    logic w_grant_d;
    logic w_grant_p;
    logic w_grant;
    logic w_in_idle;
    logic w_in_access;
    logic w_in_done;
    logic w_ctr_zero;
    logic w_capture;

    assign w_in_idle   = (r_state == IDLE);
    assign w_in_access = (r_state == ACCESS);
    assign w_in_done   = (r_state == DONE);

    assign w_p_req   = i_p_re | i_p_we;
    assign w_starved = (r_starve == ST_SAT);
    // DMA only beats a requesting pipeline once it has lost STARVE_MAX times in a row.
    assign w_grant_d = w_in_idle & i_d_req & (~w_p_req | w_starved);
    assign w_grant_p = w_in_idle & w_p_req & ~w_grant_d;
    assign w_grant   = w_grant_d | w_grant_p;
    assign w_capture = w_in_access & w_ctr_zero & ~r_we;

    dmem_lat_ctr #(
        .WIDTH (CTR_W)
    ) u_lat_ctr (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_grant),
        .i_load_val (LAT_LOAD),
        .i_dec      (w_in_access),
        .o_zero     (w_ctr_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        o_m_re    = 1'b0;
        o_m_we    = 1'b0;
        o_m_addr  = '0;
        o_m_wdata = '0;
        o_d_gnt   = 1'b0;
        o_d_done  = 1'b0;
        unique case (r_state)
            IDLE: begin
                o_d_gnt = w_grant_d;
                if (w_grant) begin
                    w_state_d = ACCESS;
                end
            end
            ACCESS: begin
                o_m_re    = ~r_we;
                o_m_we    = r_we;
                o_m_addr  = r_addr;
                o_m_wdata = r_wdata;
                if (w_ctr_zero) begin
                    w_state_d = DONE;
                end
            end
            DONE: begin
                o_d_done  = (r_owner == OWN_DMA);
                w_state_d = IDLE;
            end
            default: begin
                w_state_d = IDLE;
            end
        endcase
    end

    // Request capture: simultaneous p_re and p_we is a write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_owner <= OWN_PIPE;
            r_addr  <= '0;
            r_wdata <= '0;
            r_we    <= 1'b0;
        end else if (w_grant) begin
            r_owner <= w_grant_d ? OWN_DMA : OWN_PIPE;
            r_addr  <= w_grant_d ? i_d_addr : i_p_addr;
            r_wdata <= w_grant_d ? i_d_wdata : i_p_wdata;
            r_we    <= w_grant_d ? i_d_we : i_p_we;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_starve <= '0;
        end else if (w_grant_d) begin
            r_starve <= '0;
        end else if (w_grant_p && i_d_req && !w_starved) begin
            r_starve <= r_starve + ST_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_p_rdata <= '0;
            r_d_rdata <= '0;
        end else if (w_capture) begin
            if (r_owner == OWN_PIPE) begin
                r_p_rdata <= i_m_rdata;
            end else begin
                r_d_rdata <= i_m_rdata;
            end
        end
    end

    assign o_p_rdata = r_p_rdata;
    assign o_d_rdata = r_d_rdata;
    assign o_p_stall = w_p_req & ~(w_in_done & (r_owner == OWN_PIPE));

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized bench for dmem_arbiter against a transaction-level schedule model.
module tb_dmem_arbiter;

    localparam int LAT    = 4;
    localparam int STARVE = 3;
    localparam int PER    = LAT + 2;

    logic        clk;
    logic        rst_n;
    logic        p_re;
    logic        p_we;
    logic [15:0] p_addr;
    logic [15:0] p_wdata;
    logic [15:0] p_rdata;
    logic        p_stall;
    logic        d_req;
    logic        d_we;
    logic [15:0] d_addr;
    logic [15:0] d_wdata;
    logic        d_gnt;
    logic        d_done;
    logic [15:0] d_rdata;
    logic [15:0] m_addr;
    logic [15:0] m_wdata;
    logic        m_re;
    logic        m_we;
    logic [15:0] m_rdata;

    dmem_arbiter #(
        .ADDR_W     (16),
        .DATA_W     (16),
        .MEM_LAT    (LAT),
        .STARVE_MAX (STARVE)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_p_re    (p_re),
        .i_p_we    (p_we),
        .i_p_addr  (p_addr),
        .i_p_wdata (p_wdata),
        .o_p_rdata (p_rdata),
        .o_p_stall (p_stall),
        .i_d_req   (d_req),
        .i_d_we    (d_we),
        .i_d_addr  (d_addr),
        .i_d_wdata (d_wdata),
        .o_d_gnt   (d_gnt),
        .o_d_done  (d_done),
        .o_d_rdata (d_rdata),
        .o_m_addr  (m_addr),
        .o_m_wdata (m_wdata),
        .o_m_re    (m_re),
        .o_m_we    (m_we),
        .i_m_rdata (m_rdata)
    );

    // Data_Memory stand-in: asynchronous read, write on the clock edge.
    logic [15:0] mem [0:65535];
    assign m_rdata = mem[m_addr];
    always @(posedge clk) begin
        if (m_we) mem[m_addr] <= m_wdata;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks  = 0;
    int n_pass    = 0;
    int cur_round = 0;
    int cur_cyc   = 0;
    int m_starve  = 0;

    logic [15:0] ref_mem [0:63];
    logic [15:0] exp_p_rdata;
    logic [15:0] exp_d_rdata;

    logic [1:0]  op_kind [8];   // 0 read, 1 write, 2 read+write
    logic [15:0] op_addr [8];
    logic [15:0] op_data [8];
    bit          dma_we;
    logic [15:0] dma_addr;
    logic [15:0] dma_wdata;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s round %0d cycle %0d: got %0h expected %0h",
                     tag, cur_round, cur_cyc, got, exp);
        end
    endtask

    task automatic op_info(input int own, output logic [15:0] a, output logic [15:0] wd,
                           output bit rd, output bit wr);
        if (own < 0) begin
            a  = dma_addr;
            wd = dma_wdata;
            wr = dma_we;
            rd = !dma_we;
        end else begin
            a  = op_addr[own];
            wd = op_data[own];
            wr = (op_kind[own] != 2'd0);
            rd = (op_kind[own] == 2'd0);
        end
    endtask

    task automatic run_round(input int n_pipe, input bit d_en);
        int          order[$];
        logic [15:0] exp_rd[$];
        int          pi;
        int          pdone;
        int          total;
        int          k;
        int          ph;
        int          gd;
        int          own;
        bit          dpend;
        bit          rd;
        bit          wr;
        bit          acc;
        bit          dn;
        logic [15:0] a;
        logic [15:0] wd;

        cur_round++;
        pi    = 0;
        dpend = d_en;
        gd    = -100;
        // Grant order from the arbitration rules.
        while (pi < n_pipe || dpend) begin
            if (pi < n_pipe && (!dpend || m_starve < STARVE)) begin
                if (dpend) m_starve++;
                order.push_back(pi);
                pi++;
            end else begin
                gd = order.size() * PER;
                order.push_back(-1);
                m_starve = 0;
                dpend    = 1'b0;
            end
        end
        total = order.size();
        for (int j = 0; j < total; j++) begin
            op_info(order[j], a, wd, rd, wr);
            if (wr) ref_mem[a[5:0]] = wd;
            exp_rd.push_back(ref_mem[a[5:0]]);
        end

        pdone = 0;
        for (int c = 0; c <= total * PER; c++) begin
            @(negedge clk);
            cur_cyc = c;
            k  = c / PER;
            ph = c % PER;
            if (pdone < n_pipe) begin
                p_re    = (op_kind[pdone] != 2'd1);
                p_we    = (op_kind[pdone] != 2'd0);
                p_addr  = op_addr[pdone];
                p_wdata = op_data[pdone];
            end else begin
                p_re    = 1'b0;
                p_we    = 1'b0;
                p_addr  = 16'($urandom);
                p_wdata = 16'($urandom);
            end
            if (d_en && c <= gd) begin
                d_req   = 1'b1;
                d_we    = dma_we;
                d_addr  = dma_addr;
                d_wdata = dma_wdata;
            end else if (d_en && c < gd + PER - 1) begin
                d_req   = 1'($urandom);
                d_we    = 1'($urandom);
                d_addr  = 16'($urandom);
                d_wdata = 16'($urandom);
            end else begin
                d_req   = 1'b0;
                d_we    = 1'($urandom);
                d_addr  = 16'($urandom);
                d_wdata = 16'($urandom);
            end
            #1;
            if (k < total) begin
                own = order[k];
                op_info(own, a, wd, rd, wr);
            end else begin
                own = 0;
                a   = 16'h0;
                wd  = 16'h0;
                rd  = 1'b0;
                wr  = 1'b0;
            end
            acc = (k < total) && (ph >= 1) && (ph <= LAT);
            dn  = (k < total) && (ph == PER - 1);
            check("m_re", 32'(m_re), 32'(acc && rd));
            check("m_we", 32'(m_we), 32'(acc && wr));
            check("m_addr", 32'(m_addr), acc ? 32'(a) : 32'h0);
            check("m_wdata", 32'(m_wdata), acc ? 32'(wd) : 32'h0);
            check("d_gnt", 32'(d_gnt), 32'((k < total) && (ph == 0) && (own < 0)));
            check("d_done", 32'(d_done), 32'(dn && (own < 0)));
            check("p_stall", 32'(p_stall), 32'((pdone < n_pipe) && !(dn && own >= 0)));
            if (dn && own >= 0 && rd) exp_p_rdata = exp_rd[k];
            if (dn && own < 0 && rd) exp_d_rdata = exp_rd[k];
            check("p_rdata", 32'(p_rdata), 32'(exp_p_rdata));
            check("d_rdata", 32'(d_rdata), 32'(exp_d_rdata));
            if (dn && own >= 0) pdone++;
        end
    endtask

    task automatic gen_ops(input int n);
        for (int i = 0; i < n; i++) begin
            op_kind[i] = 2'($urandom_range(0, 2));
            op_addr[i] = 16'($urandom_range(0, 63));
            op_data[i] = 16'($urandom);
        end
        dma_we    = 1'($urandom);
        dma_addr  = 16'($urandom_range(0, 63));
        dma_wdata = 16'($urandom);
    endtask

    task automatic reset_mid_access();
        cur_round++;
        @(negedge clk);
        cur_cyc = 0;
        p_re    = 1'b0;
        p_we    = 1'b0;
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 16'hFFFF;
        d_wdata = 16'hA5A5;
        #1 check("rst_gnt", 32'(d_gnt), 32'h1);
        @(negedge clk);
        cur_cyc = 1;
        d_req   = 1'b0;
        #1 check("rst_acc1_we", 32'(m_we), 32'h1);
        @(negedge clk);
        cur_cyc = 2;
        #1 check("rst_acc2_we", 32'(m_we), 32'h1);
        rst_n = 1'b0;
        #1;
        check("rst_async_we", 32'(m_we), 32'h0);
        check("rst_async_addr", 32'(m_addr), 32'h0);
        check("rst_async_wdata", 32'(m_wdata), 32'h0);
        m_starve    = 0;
        exp_p_rdata = 16'h0;
        exp_d_rdata = 16'h0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_hold_done", 32'(d_done), 32'h0);
        check("rst_p_rdata", 32'(p_rdata), 32'h0);
        check("rst_d_rdata", 32'(d_rdata), 32'h0);
        rst_n = 1'b1;
        for (int i = 0; i < PER; i++) begin
            @(negedge clk);
            cur_cyc = 3 + i;
            #1;
            check("rst_no_done", 32'(d_done), 32'h0);
            check("rst_no_we", 32'(m_we), 32'h0);
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        p_re        = 1'b0;
        p_we        = 1'b0;
        p_addr      = 16'h0;
        p_wdata     = 16'h0;
        d_req       = 1'b0;
        d_we        = 1'b0;
        d_addr      = 16'h0;
        d_wdata     = 16'h0;
        exp_p_rdata = 16'h0;
        exp_d_rdata = 16'h0;
        for (int i = 0; i < 65536; i++) mem[i] = 16'h0;
        for (int i = 0; i < 64; i++) begin
            ref_mem[i] = 16'($urandom);
            mem[i]     = ref_mem[i];
        end
        ref_mem[16] = 16'hBEEF;
        mem[16]     = 16'hBEEF;

        repeat (2) @(negedge clk);
        #1;
        check("rst_m_re", 32'(m_re), 32'h0);
        check("rst_m_we", 32'(m_we), 32'h0);
        check("rst_m_addr", 32'(m_addr), 32'h0);
        check("rst_m_wdata", 32'(m_wdata), 32'h0);
        check("rst_d_gnt", 32'(d_gnt), 32'h0);
        check("rst_d_done", 32'(d_done), 32'h0);
        check("rst_p_rdata", 32'(p_rdata), 32'h0);
        check("rst_d_rdata", 32'(d_rdata), 32'h0);
        check("rst_stall_idle", 32'(p_stall), 32'h0);
        p_re = 1'b1;
        #1 check("rst_stall_req", 32'(p_stall), 32'h1);
        p_re = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b1;

        // Pipeline read of 0x0010.
        op_kind[0] = 2'd0; op_addr[0] = 16'h0010; op_data[0] = 16'h5555;
        run_round(1, 1'b0);
        // Pipeline write 0x0020 then read it back.
        op_kind[0] = 2'd1; op_addr[0] = 16'h0020; op_data[0] = 16'h1234;
        op_kind[1] = 2'd0; op_addr[1] = 16'h0020; op_data[1] = 16'h0000;
        run_round(2, 1'b0);
        check("wr_rd_back", 32'(p_rdata), 32'h1234);
        // DMA alone reading 0x0010.
        dma_we = 1'b0; dma_addr = 16'h0010; dma_wdata = 16'h7777;
        run_round(0, 1'b1);
        check("dma_rd", 32'(d_rdata), 32'hBEEF);
        // Contention: pipeline wins three, DMA the fourth; then again to show the clear.
        gen_ops(6);
        run_round(6, 1'b1);
        gen_ops(4);
        run_round(4, 1'b1);

        reset_mid_access();

        // Simultaneous p_re & p_we.
        op_kind[0] = 2'd2; op_addr[0] = 16'h0030; op_data[0] = 16'hC0DE;
        op_kind[1] = 2'd0; op_addr[1] = 16'h0030; op_data[1] = 16'h0000;
        run_round(2, 1'b0);

        for (int r = 0; r < 40; r++) begin
            int  n;
            bit  de;
            n  = $urandom_range(0, 5);
            de = (n == 0) ? 1'b1 : 1'($urandom);
            gen_ops(n);
            run_round(n, de);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Sequences and shares the single-port data memory between the pipeline MEM stage and a DMA/debug loader port. It latches one request at a time and holds the memory controls stable for a fixed multi-cycle access latency. It stalls the pipeline until the pipeline's own access completes. A starvation counter guarantees DMA progress under continuous pipeline traffic. It sits between the MEM stage and the Data_Memory instance.

## Interface
- ADDR_W, 16, address width
- DATA_W, 16, data width
- MEM_LAT, 4, memory access cycles (>=1)
- STARVE_MAX, 3, consecutive DMA losses before DMA is forced to win
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- p_re / p_we  in  1  pipeline read / write request; level, held while p_stall=1
- p_addr  in  ADDR_W  pipeline address (ALU result)
- p_wdata  in  DATA_W  pipeline store data
- p_rdata  out  DATA_W  pipeline load data, valid when p_stall falls
- p_stall  out  1  freeze pipeline
- d_req / d_we  in  1  DMA request / write select
- d_addr / d_wdata  in  ADDR_W / DATA_W  DMA address / data
- d_gnt  out  1  one-cycle pulse: DMA request latched
- d_done  out  1  one-cycle pulse: DMA access complete
- d_rdata  out  DATA_W  DMA read data, valid with d_done
- m_addr / m_wdata  out  ADDR_W / DATA_W  to memory
- m_re / m_we  out  1  to memory
- m_rdata  in  DATA_W  from memory

## Operation
- States: IDLE, ACCESS, DONE. The registered owner is PIPE or DMA.
- IDLE: the arbiter evaluates requests each cycle.
  - Pipeline requests when p_re|p_we. DMA requests when d_req.
  - If both request, the pipeline wins unless starve_cnt==STARVE_MAX, in which case DMA wins.
  - On grant: latch addr, wdata and we (we = p_we or d_we); load the latency counter with MEM_LAT-1; go to ACCESS. A DMA grant pulses d_gnt in the same cycle.
- ACCESS:
  - m_addr, m_wdata and m_re/m_we are driven from the latched values for exactly MEM_LAT cycles.
  - The counter decrements each cycle.
  - On the cycle the counter reads 0: capture m_rdata into the owner's rdata register (reads only); go to DONE.
- DONE:
  - Memory controls are 0.
  - Owner PIPE: p_stall=0. Owner DMA: d_done=1.
  - Next state is always IDLE.
- p_stall = (p_re|p_we) & ~(state==DONE & owner==PIPE). This is combinational.
- starve_cnt:
  - Increments (saturating at STARVE_MAX) when d_req=1 in IDLE and the pipeline is granted.
  - Clears on DMA grant.
- p_re & p_we together: treated as a write; no read data is captured.
- On writes, p_rdata and d_rdata hold their previous values.
- DMA may drop d_req before d_gnt (request withdrawn). After d_gnt, DMA inputs are ignored until d_done.
- DMA must hold d_req low for at least one cycle after d_done before starting a new request.

## Timing
- Pipeline request first seen in IDLE at cycle t, granted:
  - ACCESS spans t+1..t+MEM_LAT.
  - DONE is at t+MEM_LAT+1: p_stall=0 and p_rdata valid.
  - Total stall is MEM_LAT+1 cycles.
- Back-to-back pipeline accesses: the new request is seen in IDLE at t+MEM_LAT+2.
- DMA: d_gnt at t, d_done at t+MEM_LAT+1.
- Pipeline waiting behind DMA: stall extends by MEM_LAT+2 cycles.
- Reset values:
  - State IDLE, owner PIPE, counter 0, starve_cnt 0.
  - m_re, m_we, m_addr and m_wdata are 0.
  - d_gnt and d_done are 0.
  - p_rdata and d_rdata are 0.
  - p_stall follows p_re|p_we.
- Reset mid-ACCESS: memory controls drop immediately (asynchronous). The access is aborted and no d_done is issued. Memory contents at the aborted address are undefined.

## Structure
- Package wisc_mem_pkg holds:
  - state_t {IDLE, ACCESS, DONE}
  - owner_t {OWN_PIPE, OWN_DMA}
  - DMEM_ADDR_W and DMEM_DATA_W constants
  - default MEM_LAT
- One sub-module, dmem_lat_ctr: a loadable down-counter with a zero flag, $clog2(MEM_LAT+1) bits wide, async reset.
- All other logic lives in dmem_arbiter. Data_Memory is instantiated by the parent, not inside this block.

## Test plan
All scenarios use MEM_LAT=4 and STARVE_MAX=3.
- Pipeline read:
  - Stimulus: mem[0x0010]=0xBEEF, then p_re=1, p_addr=0x0010 at cycle 0.
  - Response: m_re=1 for cycles 1-4, p_stall=1 for cycles 0-4, p_stall=0 and p_rdata=0xBEEF at cycle 5.
- Pipeline write:
  - Stimulus: p_we=1, addr 0x0020, data 0x1234.
  - Response: m_we=1 for 4 cycles. A subsequent read of 0x0020 returns 0x1234, and p_rdata is unchanged during the write.
- DMA alone:
  - Stimulus: d_req=1, d_we=0, d_addr=0x0010.
  - Response: d_gnt at cycle 0, d_done and d_rdata=0xBEEF at cycle 5. Changing d_addr after d_gnt has no effect.
- Contention and starvation:
  - Stimulus: pipeline requests continuously, d_req=1 from cycle 0.
  - Response: the pipeline wins 3 grants, DMA wins the 4th, and starve_cnt returns to 0.
- Reset mid-access:
  - Stimulus: DMA write starts, rst_n=0 at the 2nd ACCESS cycle.
  - Response: m_we=0 asynchronously, no d_done, state IDLE after release.
- Simultaneous p_re & p_we:
  - Response: treated as a write, m_re never asserted, p_rdata held.
